sram_tile_dma: RTL and testbench

Sequencing stage that sits directly in front of a single-port feature/weight `SRAM` instance and owns all of its ports. Two operations are supported:
- **LOAD:** moves a contiguous run of words from an upstream valid/ready stream into the SRAM.
- **DRAIN:** streams a contiguous run of SRAM words out to the downstream compute array over valid/ready.

Each operation is started by a one-cycle command and ends with a one-cycle `done` pulse.

---
 rtl/sram_tile_dma.sv | 158 +++++++++++++++
 tb/tb_sram_tile_dma.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_tile_dma.sv
// ---------------------------------------------------------------------------
// sram_tile_dma
//
// Sequencer that owns every port of one single-port feature/weight SRAM.
// It runs one command at a time:
//   LOAD  : copies `count` words from the upstream stream into the SRAM,
//           starting at `base`.
//   DRAIN : streams `count` SRAM words, starting at `base`, to the downstream
//           compute array through a registered output stage.
// A command is a one-cycle `start` strobe. Completion is a one-cycle `done`
// pulse.
//
// Handshake rule for both streams: a word moves on a rising edge where
// valid and ready are both high. A producer holds valid and its data
// steady until that edge. Ready may depend combinationally on state only,
// never on the partner's valid.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   start, mode         command strobe (IDLE only); 0 = LOAD, 1 = DRAIN
//   base, count         first address, word count (0 .. 2^A)
//   busy, done          busy in LOAD/DRAIN/DONE; done pulses in DONE
//   in_data/valid/ready upstream stream (ready only in LOAD)
//   out_data/valid/ready downstream stream (data and valid registered)
//   sram_*              SRAM address/data/write; dataOutput is a
//                       combinational read of sram_address
//   dbg_state           current FSM state (IDLE=0 LOAD=1 DRAIN=2 DONE=3)
// ---------------------------------------------------------------------------
module sram_tile_dma #(
    parameter int A = 7,
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic         mode,
    input  logic [A-1:0] base,
    input  logic [A:0]   count,
    output logic         busy,
    output logic         done,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [A-1:0] sram_address,
    output logic [W-1:0] sram_dataInput,
    output logic         sram_write,
    input  logic [W-1:0] sram_dataOutput,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [A-1:0] PTR_ONE  = {{(A-1){1'b0}}, 1'b1};
    localparam logic [A:0]   REM_ZERO = '0;
    localparam logic [A:0]   REM_ONE  = {{A{1'b0}}, 1'b1};

    state_t         state_q;
    logic [A-1:0]   ptr_q;
    logic [A:0]     remaining_q;
    logic [W-1:0]   out_data_q;
    logic           out_valid_q;

    logic           load_hs;
    logic           out_loadable;

    // The output register may take a new word when it is empty or when its
    // current word leaves on this edge.
    assign out_loadable = !out_valid_q || out_ready;
    assign load_hs      = (state_q == ST_LOAD) && in_valid;

    // ------------------------------------------------------------------
    // FSM and datapath registers. The command mode is not stored
    // separately: it is fully captured by the LOAD/DRAIN state chosen at
    // `start`.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q       <= base;
                        remaining_q <= count;
                        if (count == REM_ZERO) begin
                            state_q <= ST_DONE;
                        end else if (mode) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (load_hs) begin
                        ptr_q       <= ptr_q + PTR_ONE;
                        remaining_q <= remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_DRAIN: begin
                    // The SRAM read is combinational on ptr, so the word
                    // addressed this cycle is captured on this same edge.
                    if (out_loadable) begin
                        if (remaining_q != REM_ZERO) begin
                            out_data_q  <= sram_dataOutput;
                            out_valid_q <= 1'b1;
                            ptr_q       <= ptr_q + PTR_ONE;
                            remaining_q <= remaining_q - REM_ONE;
                        end else begin
                            // Last word has been taken downstream.
                            out_valid_q <= 1'b0;
                            state_q     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign in_ready       = (state_q == ST_LOAD);
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign sram_address   = ptr_q;
    assign sram_dataInput = in_data;
    assign sram_write     = load_hs;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_sram_tile_dma.sv
module tb_sram_tile_dma;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        mode;
  logic [6:0]  base;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  sram_address;
  logic [15:0] sram_dataInput;
  logic        sram_write;
  logic [15:0] sram_dataOutput;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  logic [15:0] mem [128];
  logic [15:0] exp_q[$];

  sram_tile_dma #(.A(7), .W(16)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .start           (start),
    .mode            (mode),
    .base            (base),
    .count           (count),
    .busy            (busy),
    .done            (done),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .sram_address    (sram_address),
    .sram_dataInput  (sram_dataInput),
    .sram_write      (sram_write),
    .sram_dataOutput (sram_dataOutput),
    .dbg_state       (dbg_state)
  );

  // clock / SRAM model
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (sram_write) mem[sram_address] = sram_dataInput;
  end
  assign sram_dataOutput = mem[sram_address];

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1 of cycle t; returns at posedge+1 of cycle t+1.
  task automatic cmd(input logic m, input logic [6:0] b, input logic [7:0] c);
    start = 1'b1; mode = m; base = b; count = c;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", sram_write); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    checks++; if (sram_address !== 7'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", sram_address); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    step(); step();
    RST_N = 1'b1;
    step();
    // async reset in the middle of a LOAD cycle
    in_valid = 1'b0;
    cmd(1'b0, 7'd3, 8'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    in_valid = 1'b1; in_data = 16'h5555;
    #2 RST_N = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write: got %b want 0", sram_write); end
    step();
    in_valid = 1'b0;
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_load_full();
    logic [15:0] w;
    in_valid = 1'b0;
    cmd(1'b0, 7'd5, 8'd4);
    for (int c = 1; c <= 6; c++) begin
      in_valid = (c <= 4);
      in_data  = 16'h00A0 + 16'(c - 1);
      #1;
      checks++; if (sram_write !== (c <= 4)) begin errors++; $display("FAIL load_write c%0d: got %b want %b", c, sram_write, (c <= 4)); end
      if (c <= 4) begin
        checks++; if (sram_address !== 7'(4 + c)) begin errors++; $display("FAIL load_addr c%0d: got %0d want %0d", c, sram_address, 4 + c); end
        checks++; if (sram_dataInput !== 16'h00A0 + 16'(c - 1)) begin errors++; $display("FAIL load_din c%0d: got %h", c, sram_dataInput); end
      end
      checks++; if (done !== (c == 5)) begin errors++; $display("FAIL load_done c%0d: got %b want %b", c, done, (c == 5)); end
      checks++; if (busy !== (c <= 5)) begin errors++; $display("FAIL load_busy c%0d: got %b want %b", c, busy, (c <= 5)); end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = mem[5 + i];
      checks++; if (w !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL load_mem %0d: got %h want %h", 5 + i, w, 16'h00A0 + 16'(i)); end
    end
    // drain the same range at full rate
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h00A0 + 16'(i));
    out_ready = 1'b1;
    cmd(1'b1, 7'd5, 8'd4);
    for (int c = 1; c <= 7; c++) begin
      #1;
      checks++; if (out_valid !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL drain_valid c%0d: got %b want %b", c, out_valid, (c >= 2 && c <= 5)); end
      if (c >= 2 && c <= 5) begin
        w = exp_q.pop_front();
        checks++; if (out_data !== w) begin errors++; $display("FAIL drain_data c%0d: got %h want %h", c, out_data, w); end
      end
      checks++; if (done !== (c == 6)) begin errors++; $display("FAIL drain_done c%0d: got %b want %b", c, done, (c == 6)); end
      checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL drain_write c%0d: got %b want 0", c, sram_write); end
      step();
    end
  endtask

  task automatic test_wrap_stall();
    logic        rdy [1:10];
    logic        vld [1:10];
    logic [15:0] dat [1:10];
    mem[126] = 16'hB126; mem[127] = 16'hB127; mem[0] = 16'hB000; mem[1] = 16'hB001;
    rdy = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    vld = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    dat = '{16'h0, 16'hB126, 16'hB127, 16'hB127, 16'hB127, 16'hB127, 16'hB000, 16'hB001, 16'h0, 16'h0};
    out_ready = 1'b1;
    cmd(1'b1, 7'd126, 8'd4);
    for (int c = 1; c <= 10; c++) begin
      out_ready = rdy[c];
      #1;
      checks++; if (out_valid !== vld[c]) begin errors++; $display("FAIL wrap_valid c%0d: got %b want %b", c, out_valid, vld[c]); end
      if (vld[c]) begin
        checks++; if (out_data !== dat[c]) begin errors++; $display("FAIL wrap_data c%0d: got %h want %h", c, out_data, dat[c]); end
      end
      if (c >= 3 && c <= 5) begin
        checks++; if (sram_address !== 7'd0) begin errors++; $display("FAIL wrap_stall_addr c%0d: got %0d want 0", c, sram_address); end
      end
      checks++; if (done !== (c == 9)) begin errors++; $display("FAIL wrap_done c%0d: got %b want %b", c, done, (c == 9)); end
      step();
    end
  endtask

  task automatic test_bubbly_load();
    logic       iv [1:7];
    logic [6:0] ad [1:7];
    int         pulses;
    logic [15:0] w;
    iv = '{1, 0, 0, 1, 1, 1, 1};
    ad = '{7'd20, 7'd21, 7'd21, 7'd21, 7'd22, 7'd23, 7'd23};
    pulses = 0;
    in_valid = 1'b0;
    mem[23] = 16'h0000;
    cmd(1'b0, 7'd20, 8'd3);
    for (int c = 1; c <= 7; c++) begin
      in_valid = iv[c];
      in_data  = 16'h00C0 + 16'(c - 1);
      #1;
      if (sram_write === 1'b1) pulses++;
      checks++; if (sram_write !== (c == 1 || c == 4 || c == 5)) begin errors++; $display("FAIL bub_write c%0d: got %b", c, sram_write); end
      checks++; if (in_ready !== (c <= 5)) begin errors++; $display("FAIL bub_in_ready c%0d: got %b want %b", c, in_ready, (c <= 5)); end
      if (c <= 6) begin
        checks++; if (sram_address !== ad[c]) begin errors++; $display("FAIL bub_addr c%0d: got %0d want %0d", c, sram_address, ad[c]); end
      end
      checks++; if (done !== (c == 6)) begin errors++; $display("FAIL bub_done c%0d: got %b want %b", c, done, (c == 6)); end
      step();
    end
    in_valid = 1'b0;
    checks++; if (pulses != 3) begin errors++; $display("FAIL bub_pulses: got %0d want 3", pulses); end
    w = mem[20]; checks++; if (w !== 16'h00C0) begin errors++; $display("FAIL bub_mem20: got %h want 00c0", w); end
    w = mem[21]; checks++; if (w !== 16'h00C3) begin errors++; $display("FAIL bub_mem21: got %h want 00c3", w); end
    w = mem[22]; checks++; if (w !== 16'h00C4) begin errors++; $display("FAIL bub_mem22: got %h want 00c4", w); end
    w = mem[23]; checks++; if (w !== 16'h0000) begin errors++; $display("FAIL bub_mem23: got %h want 0000", w); end
  endtask

  task automatic test_edge_cmds();
    logic [15:0] w;
    // count = 0 with upstream data offered
    in_valid = 1'b1; in_data = 16'hDEAD;
    cmd(1'b0, 7'd50, 8'd0);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL zero_write: got %b want 0", sram_write); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", busy); end
    // start pulsed during a LOAD must be ignored
    in_valid = 1'b1; in_data = 16'h00D0;
    cmd(1'b0, 7'd40, 8'd3);
    step();
    in_valid = 1'b0;
    start = 1'b1; mode = 1'b1; base = 7'd100; count = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h00D1;
    #1;
    checks++; if (sram_address !== 7'd41) begin errors++; $display("FAIL ign_addr1: got %0d want 41", sram_address); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ign_in_ready: got %b want 1", in_ready); end
    step();
    in_data = 16'h00D2;
    #1;
    checks++; if (sram_address !== 7'd42) begin errors++; $display("FAIL ign_addr2: got %0d want 42", sram_address); end
    step();
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", done); end
    w = mem[41]; checks++; if (w !== 16'h00D1) begin errors++; $display("FAIL ign_mem41: got %h want 00d1", w); end
    w = mem[42]; checks++; if (w !== 16'h00D2) begin errors++; $display("FAIL ign_mem42: got %h want 00d2", w); end
    step();
  endtask

  task automatic test_back_to_back();
    // start issued in the cycle right after done
    in_valid = 1'b0;
    cmd(1'b0, 7'd60, 8'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", done); end
    step();
    cmd(1'b1, 7'd61, 8'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 10; i++) mem[70 + i] = 16'h00E0 + 16'(i);
    out_ready = 1'b1;
    cmd(1'b1, 7'd70, 8'd10);
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c >= 2) begin
        checks++; if (out_data !== 16'h00E0 + 16'(c - 2)) begin errors++; $display("FAIL rmd_data c%0d: got %h want %h", c, out_data, 16'h00E0 + 16'(c - 2)); end
      end
      step();
    end
    #1 RST_N = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmd_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmd_busy: got %b want 0", busy); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmd_no_done %0d: got %b want 0", c, done); end
    end
    RST_N = 1'b1;
    step();
    cmd(1'b1, 7'd72, 8'd2);
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (out_valid !== (c == 2 || c == 3)) begin errors++; $display("FAIL rmd2_valid c%0d: got %b", c, out_valid); end
      if (c == 2 || c == 3) begin
        checks++; if (out_data !== 16'h00E2 + 16'(c - 2)) begin errors++; $display("FAIL rmd2_data c%0d: got %h want %h", c, out_data, 16'h00E2 + 16'(c - 2)); end
      end
      checks++; if (done !== (c == 4)) begin errors++; $display("FAIL rmd2_done c%0d: got %b", c, done); end
      step();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    start = 1'b0; mode = 1'b0; base = '0; count = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_load_full();
    test_wrap_stall();
    test_bubbly_load();
    test_edge_cmds();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
